// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory port seen by mem_port_arbiter.
// slave = the arbiter's view, master = the core/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  // Handshake: a port raises *_req with stable fields and holds both until it sees its *_gnt
  // pulse; its *_rsp_valid pulse later carries rdata/err. mem_req is a one-cycle issue strobe
  // and mem_rvalid a one-cycle completion strobe carrying mem_rdata.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rsp_valid;
  logic [31:0]       if_rdata;
  logic              if_rsp_err;

  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic              ls_sign_extend;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_gnt;
  logic              ls_rsp_valid;
  logic [31:0]       ls_rdata;
  logic              ls_rsp_err;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic              mem_sign_extend;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rsp_valid, if_rdata, if_rsp_err,
    input  ls_req, ls_we, ls_size, ls_sign_extend, ls_addr, ls_wdata,
    output ls_gnt, ls_rsp_valid, ls_rdata, ls_rsp_err,
    output mem_req, mem_we, mem_size, mem_sign_extend, mem_addr, mem_wdata,
    input  mem_rvalid, mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rsp_valid, if_rdata, if_rsp_err,
    output ls_req, ls_we, ls_size, ls_sign_extend, ls_addr, ls_wdata,
    input  ls_gnt, ls_rsp_valid, ls_rdata, ls_rsp_err,
    input  mem_req, mem_we, mem_size, mem_sign_extend, mem_addr, mem_wdata,
    output mem_rvalid, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (IF) and load/store (LS) ports, one
// transaction at a time, with a watchdog that error-completes transactions memory never answers.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           dbg_state
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic            owner_ls;
  logic            last_ls;
  logic [WD_W-1:0] watchdog;
  logic            any_req;
  logic            pick_ls;
  logic            done;
  logic            timed_out;
  logic [31:0]     rsp_data;

  assign any_req   = bus.if_req | bus.ls_req;
  assign dbg_state = state;

  // Under contention LS wins outright, or in round-robin the port that did not go last.
  always_comb begin
    pick_ls = bus.ls_req;
    if (bus.ls_req && bus.if_req) begin
      pick_ls = (RR_MODE != 0) ? ~last_ls : 1'b1;
    end
  end

  // The watchdog holds the count of WAIT cycles already spent; completion in its last cycle
  // still prefers a real mem_rvalid over the timeout.
  always_comb begin
    done      = (state == ST_WAIT) && (bus.mem_rvalid || (watchdog == WD_LAST));
    timed_out = ~bus.mem_rvalid;
    rsp_data  = (bus.mem_rvalid && !bus.mem_we) ? bus.mem_rdata : 32'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= ST_IDLE;
      owner_ls            <= 1'b0;
      last_ls             <= 1'b1;
      watchdog            <= '0;
      bus.if_gnt          <= 1'b0;
      bus.if_rsp_valid    <= 1'b0;
      bus.if_rdata        <= 32'd0;
      bus.if_rsp_err      <= 1'b0;
      bus.ls_gnt          <= 1'b0;
      bus.ls_rsp_valid    <= 1'b0;
      bus.ls_rdata        <= 32'd0;
      bus.ls_rsp_err      <= 1'b0;
      bus.mem_req         <= 1'b0;
      bus.mem_we          <= 1'b0;
      bus.mem_size        <= 2'b00;
      bus.mem_sign_extend <= 1'b0;
      bus.mem_addr        <= {ADDR_W{1'b0}};
      bus.mem_wdata       <= 32'd0;
      bus.busy            <= 1'b0;
    end else begin
      bus.if_gnt       <= 1'b0;
      bus.ls_gnt       <= 1'b0;
      bus.mem_req      <= 1'b0;
      bus.if_rsp_valid <= 1'b0;
      bus.if_rdata     <= 32'd0;
      bus.if_rsp_err   <= 1'b0;
      bus.ls_rsp_valid <= 1'b0;
      bus.ls_rdata     <= 32'd0;
      bus.ls_rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state               <= ST_ISSUE;
            owner_ls            <= pick_ls;
            last_ls             <= pick_ls;
            watchdog            <= '0;
            bus.busy            <= 1'b1;
            bus.mem_req         <= 1'b1;
            bus.if_gnt          <= ~pick_ls;
            bus.ls_gnt          <= pick_ls;
            // Fetches are always word reads.
            bus.mem_we          <= pick_ls & bus.ls_we;
            bus.mem_size        <= pick_ls ? bus.ls_size : 2'b10;
            bus.mem_sign_extend <= pick_ls & bus.ls_sign_extend;
            bus.mem_addr        <= pick_ls ? bus.ls_addr : bus.if_addr;
            bus.mem_wdata       <= pick_ls ? bus.ls_wdata : 32'd0;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            state               <= ST_IDLE;
            bus.busy            <= 1'b0;
            bus.mem_we          <= 1'b0;
            bus.mem_size        <= 2'b00;
            bus.mem_sign_extend <= 1'b0;
            bus.mem_addr        <= {ADDR_W{1'b0}};
            bus.mem_wdata       <= 32'd0;
            if (owner_ls) begin
              bus.ls_rsp_valid <= 1'b1;
              bus.ls_rdata     <= rsp_data;
              bus.ls_rsp_err   <= timed_out;
            end else begin
              bus.if_rsp_valid <= 1'b1;
              bus.if_rdata     <= rsp_data;
              bus.if_rsp_err   <= timed_out;
            end
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a fixed-priority and a round-robin instance, exercised in turn
// against a transaction-level timing model with an event scoreboard.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int T      = 4;
  localparam int W      = 128;
  localparam int N_RAND = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b0;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = '0;
  logic        ls_se = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) b1 ();
  logic [1:0] dbg0;
  logic [1:0] dbg1;

  assign b0.if_req = if_req & ~sel;
  assign b1.if_req = if_req & sel;
  assign b0.ls_req = ls_req & ~sel;
  assign b1.ls_req = ls_req & sel;
  assign b0.mem_rvalid = mem_rvalid & ~sel;
  assign b1.mem_rvalid = mem_rvalid & sel;
  assign b0.if_addr = if_addr;           assign b1.if_addr = if_addr;
  assign b0.ls_we = ls_we;               assign b1.ls_we = ls_we;
  assign b0.ls_size = ls_size;           assign b1.ls_size = ls_size;
  assign b0.ls_sign_extend = ls_se;      assign b1.ls_sign_extend = ls_se;
  assign b0.ls_addr = ls_addr;           assign b1.ls_addr = ls_addr;
  assign b0.ls_wdata = ls_wdata;         assign b1.ls_wdata = ls_wdata;
  assign b0.mem_rdata = mem_rdata;       assign b1.mem_rdata = mem_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .RR_MODE(0), .TIMEOUT_CYCLES(T)) dut0 (
    .clock(clock), .reset(reset), .bus(b0.slave), .dbg_state(dbg0));
  mem_port_arbiter #(.ADDR_W(ADDR_W), .RR_MODE(1), .TIMEOUT_CYCLES(T)) dut1 (
    .clock(clock), .reset(reset), .bus(b1.slave), .dbg_state(dbg1));

  logic o_if_gnt, o_if_rsp_valid, o_if_rsp_err, o_ls_gnt, o_ls_rsp_valid, o_ls_rsp_err;
  logic o_mem_req, o_mem_we, o_mem_se, o_busy;
  logic [1:0]  o_mem_size, o_dbg;
  logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
  assign o_if_gnt       = sel ? b1.if_gnt : b0.if_gnt;
  assign o_if_rsp_valid = sel ? b1.if_rsp_valid : b0.if_rsp_valid;
  assign o_if_rdata     = sel ? b1.if_rdata : b0.if_rdata;
  assign o_if_rsp_err   = sel ? b1.if_rsp_err : b0.if_rsp_err;
  assign o_ls_gnt       = sel ? b1.ls_gnt : b0.ls_gnt;
  assign o_ls_rsp_valid = sel ? b1.ls_rsp_valid : b0.ls_rsp_valid;
  assign o_ls_rdata     = sel ? b1.ls_rdata : b0.ls_rdata;
  assign o_ls_rsp_err   = sel ? b1.ls_rsp_err : b0.ls_rsp_err;
  assign o_mem_req      = sel ? b1.mem_req : b0.mem_req;
  assign o_mem_we       = sel ? b1.mem_we : b0.mem_we;
  assign o_mem_size     = sel ? b1.mem_size : b0.mem_size;
  assign o_mem_se       = sel ? b1.mem_sign_extend : b0.mem_sign_extend;
  assign o_mem_addr     = sel ? b1.mem_addr : b0.mem_addr;
  assign o_mem_wdata    = sel ? b1.mem_wdata : b0.mem_wdata;
  assign o_busy         = sel ? b1.busy : b0.busy;
  assign o_dbg          = sel ? dbg1 : dbg0;

  // Events: {cycle, kind, a, b, flags}. Kinds: 1 IF gnt, 2 LS gnt, 3 mem issue, 4 IF rsp,
  // 5 LS rsp, 6 rule violation, 7 busy rise, 8 busy fall.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           dly_q[$];
  logic [31:0]  rd_q[$];
  int unsigned  fire_c[$];
  logic [31:0]  fire_d[$];

  function automatic logic [W-1:0] evt(input int unsigned c, input logic [3:0] k,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] f);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, k, a, b, f, 40'd0};
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic        prev_busy = 1'b0;
  logic [31:0] lat_addr = '0;
  logic [31:0] lat_wdata = '0;
  logic [3:0]  lat_f = '0;
  logic [7:0]  bad;

  always @(negedge clock) begin
    bad = '0;
    if (o_if_gnt) obs_q.push_back(evt(cyc, 4'd1, '0, '0, '0));
    if (o_ls_gnt) obs_q.push_back(evt(cyc, 4'd2, '0, '0, '0));
    if (o_mem_req) begin
      lat_addr  = o_mem_addr;
      lat_wdata = o_mem_wdata;
      lat_f     = {o_mem_we, o_mem_size, o_mem_se};
      obs_q.push_back(evt(cyc, 4'd3, o_mem_addr, o_mem_wdata, lat_f));
      if (dly_q.size() > 0) begin
        fire_c.push_back(cyc + int'(dly_q.pop_front()));
        fire_d.push_back(rd_q.pop_front());
      end
    end
    if (o_busy && !prev_busy) obs_q.push_back(evt(cyc, 4'd7, '0, '0, '0));
    if (o_if_rsp_valid) obs_q.push_back(evt(cyc, 4'd4, o_if_rdata, '0, {3'b000, o_if_rsp_err}));
    if (o_ls_rsp_valid) obs_q.push_back(evt(cyc, 4'd5, o_ls_rdata, '0, {3'b000, o_ls_rsp_err}));
    if (!o_busy && prev_busy) obs_q.push_back(evt(cyc, 4'd8, '0, '0, '0));
    bad[0] = o_if_gnt & o_ls_gnt;
    bad[1] = (o_if_gnt | o_ls_gnt | o_mem_req) & ~o_busy;
    bad[2] = ~o_if_rsp_valid & ((o_if_rdata != 32'd0) | o_if_rsp_err);
    bad[3] = ~o_ls_rsp_valid & ((o_ls_rdata != 32'd0) | o_ls_rsp_err);
    bad[4] = ~o_busy & (o_mem_req | o_mem_we | o_mem_se | (o_mem_size != 2'd0) |
                        (o_mem_addr != 32'd0) | (o_mem_wdata != 32'd0));
    bad[5] = o_busy & ((o_mem_addr != lat_addr) | (o_mem_wdata != lat_wdata) |
                       ({o_mem_we, o_mem_size, o_mem_se} != lat_f));
    bad[6] = o_busy != (o_dbg != 2'd0);
    bad[7] = o_if_rsp_valid & o_ls_rsp_valid;
    if (bad != 8'd0) obs_q.push_back(evt(cyc, 4'd6, {24'd0, bad}, '0, '0));
    prev_busy = o_busy;
  end

  // Memory responder: fires mem_rvalid at the cycle scheduled when each issue was seen.
  always @(posedge clock) begin
    #2;
    while (fire_c.size() > 0 && fire_c[0] < cyc) begin
      void'(fire_c.pop_front());
      void'(fire_d.pop_front());
    end
    if (fire_c.size() > 0 && fire_c[0] == cyc) begin
      void'(fire_c.pop_front());
      mem_rvalid = 1'b1;
      mem_rdata  = fire_d.pop_front();
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
  end

  logic        last_ls = 1'b1;
  int unsigned free_c = 0;

  task automatic goto(input int unsigned n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctl"}, {o_if_gnt, o_if_rsp_valid, o_if_rsp_err, o_ls_gnt, o_ls_rsp_valid,
                             o_ls_rsp_err, o_mem_req, o_mem_we, o_mem_size, o_mem_se, o_busy}, '0);
    check_eq({tag, "_data"}, {o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata}, '0);
    check_eq({tag, "_state"}, o_dbg, '0);
  endtask

  // Model: issue at g, response at g + min(d, T) + 1, error when memory is later than T.
  task automatic expect_txn(input bit is_ls, input int unsigned g, input int d,
                            input logic [31:0] addr, input logic [31:0] wdat,
                            input logic [3:0] f, input bit store, input logic [31:0] rdat,
                            output int unsigned r);
    bit          err;
    logic [31:0] data;
    err  = (d > T);
    r    = g + int'((d > T) ? T : d) + 1;
    data = (err || store) ? 32'd0 : rdat;
    exp_q.push_back(evt(g, is_ls ? 4'd2 : 4'd1, '0, '0, '0));
    exp_q.push_back(evt(g, 4'd3, addr, wdat, f));
    exp_q.push_back(evt(g, 4'd7, '0, '0, '0));
    exp_q.push_back(evt(r, is_ls ? 4'd5 : 4'd4, data, '0, {3'b000, err}));
    exp_q.push_back(evt(r, 4'd8, '0, '0, '0));
    dly_q.push_back(d);
    rd_q.push_back(rdat);
  endtask

  task automatic scen(input bit want_if, input bit want_ls, input logic [31:0] ia,
                      input logic [31:0] la, input bit we, input logic [1:0] sz, input bit se,
                      input logic [31:0] wdat, input int d_if, input int d_ls,
                      input logic [31:0] r_if, input logic [31:0] r_ls, input int gap);
    int unsigned n, g1, r1, g2, r2;
    bit          two, first_ls;
    logic [3:0]  ls_f;
    n = ((free_c > cyc) ? free_c : cyc) + gap;
    goto(n);
    if_addr = ia; ls_addr = la; ls_we = we; ls_size = sz; ls_se = se; ls_wdata = wdat;
    if_req = want_if;
    ls_req = want_ls;
    two      = want_if & want_ls;
    first_ls = two ? (sel ? ~last_ls : 1'b1) : want_ls;
    ls_f     = {we, sz, se};
    g1 = n + 1;
    if (first_ls) expect_txn(1'b1, g1, d_ls, la, wdat, ls_f, we, r_ls, r1);
    else          expect_txn(1'b0, g1, d_if, ia, 32'd0, 4'b0100, 1'b0, r_if, r1);
    last_ls = first_ls;
    free_c  = r1;
    if (two) begin
      g2 = r1 + 1;
      if (first_ls) expect_txn(1'b0, g2, d_if, ia, 32'd0, 4'b0100, 1'b0, r_if, r2);
      else          expect_txn(1'b1, g2, d_ls, la, wdat, ls_f, we, r_ls, r2);
      last_ls = ~first_ls;
      free_c  = r2;
    end
    goto(g1 + 1);
    if (first_ls) ls_req = 1'b0;
    else          if_req = 1'b0;
    if (two) begin
      goto(g2 + 1);
      if_req = 1'b0;
      ls_req = 1'b0;
    end
  endtask

  // Load abandoned by a reset in WAIT; its memory answer arrives afterwards and must be ignored.
  task automatic reset_mid();
    int unsigned n, g;
    logic [31:0] a;
    n = (free_c > cyc) ? free_c : cyc;
    goto(n);
    a = $urandom;
    ls_addr = a; ls_we = 1'b0; ls_size = 2'b10; ls_se = 1'b0; ls_wdata = $urandom;
    ls_req = 1'b1;
    g = n + 1;
    exp_q.push_back(evt(g, 4'd2, '0, '0, '0));
    exp_q.push_back(evt(g, 4'd3, a, ls_wdata, 4'b0100));
    exp_q.push_back(evt(g, 4'd7, '0, '0, '0));
    exp_q.push_back(evt(g + 3, 4'd8, '0, '0, '0));
    dly_q.push_back(T);
    rd_q.push_back($urandom);
    goto(g + 1);
    ls_req = 1'b0;
    goto(g + 2);
    reset = 1'b1;
    goto(g + 3);
    reset = 1'b0;
    check_outputs_zero("midrst");
    last_ls = 1'b1;
    free_c  = g + T + 1;
  endtask

  task automatic start_dut(input logic s);
    reset  = 1'b1;
    if_req = 1'b0;
    ls_req = 1'b0;
    sel    = s;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    exp_q.delete(); obs_q.delete(); dly_q.delete(); rd_q.delete();
    fire_c.delete(); fire_d.delete();
    check_outputs_zero("reset");
    reset   = 1'b0;
    last_ls = 1'b1;
    free_c  = cyc;
  endtask

  task automatic finish_dut(input int s);
    int n;
    goto(free_c + T + 4);
    check_eq($sformatf("evt_count%0d", s), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("evt%0d_%0d", s, i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_dut(s[0]);
      scen(1, 0, 32'h0000_0010, 32'h0, 0, 2'b10, 0, 32'h0, 1, 1, 32'h0010_0093, 32'h0, 0);
      scen(0, 1, 32'h0, 32'h0000_0100, 1, 2'b10, 0, 32'hDEAD_BEEF, 1, 2, 32'h0, 32'h1234_5678, 1);
      for (int k = 0; k < 3; k++) begin
        scen(1, 1, $urandom, $urandom, 1'($urandom_range(0, 1)), 2'b01, 1, $urandom,
             int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), $urandom, $urandom, 0);
      end
      scen(0, 1, 32'h0, 32'h0000_0200, 0, 2'b00, 1, 32'h0, 1, T + 1, 32'h0, 32'hCAFE_F00D, 0);
      scen(0, 1, 32'h0, 32'h0000_0204, 0, 2'b01, 0, 32'h0, 1, T + 2, 32'h0, 32'h0BAD_0BAD, 1);
      scen(0, 1, 32'h0, 32'h0000_0300, 0, 2'b10, 0, 32'h0, 1, T, 32'h0, 32'h5A5A_A5A5, 0);
      scen(1, 0, 32'h0000_0044, 32'h0, 0, 2'b00, 0, 32'h0, T, 1, 32'h00C0_FFEE, 32'h0, 2);
      reset_mid();
      scen(1, 1, 32'h0000_0080, 32'h0000_0400, 0, 2'b10, 0, 32'h0, 2, 1, 32'h1111_1111,
           32'h2222_2222, 0);
      for (int i = 0; i < N_RAND; i++) begin
        int kind;
        kind = int'($urandom_range(0, 2));
        scen(kind != 1, kind != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(1, T + 2)), int'($urandom_range(1, T + 2)),
             $urandom, $urandom, int'($urandom_range(0, 2)));
      end
      finish_dut(s);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got no end of run, required end before %0d cycles", cyc);
    $fatal(1);
  end
endmodule
